ethernet_axis_receiver: RTL
===========================

# ethernet_axis_receiver

Receive-side counterpart of the Ethernet sender: accepts one frame at a time from a MAC's AXI4-Stream RX port into a single on-chip frame buffer. Reports the frame's byte count to the host, which reads the frame out by word address and then releases the buffer. Frames that arrive while the buffer is occupied, oversized frames and malformed frames are discarded and counted. Sits between the MAC RX datapath and the host/cosim register interface.

## Interface
- buf_size_p, 2048: frame buffer size in bytes; power of two.
- recv_width_p, 8: stream width in bytes; only 8 is supported, and elaboration errors otherwise.
- Derived: size_width = clog2(buf_size_p)+1; addr_width = clog2(buf_size_p/recv_width_p).

- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- rx_axis_tdata_i  in  64  stream data; byte 0 is first on the wire.
- rx_axis_tkeep_i  in  8  byte enables.
- rx_axis_tvalid_i  in  1  beat valid.
- rx_axis_tlast_i  in  1  last beat of frame.
- rx_axis_tuser_i  in  1  MAC error flag; sampled on the last beat.
- rx_axis_tready_o  out  1  beat accept.
- packet_avail_o  out  1  a good frame is held in the buffer.
- packet_size_o  out  size_width  byte count of the held frame.
- packet_ack_i  in  1  host releases the buffer.
- buffer_read_addr_i  in  addr_width  word address for host reads.
- buffer_read_data_o  out  64  registered read data.
- drop_count_o  out  16  number of discarded frames; saturates.

## Operation
- A beat is accepted on rx_axis_tvalid_i & rx_axis_tready_o.
- rx_axis_tready_o is 1 at all times out of reset. The MAC cannot be back-pressured, so overflow is handled by dropping frames.
- State machine (enum in package): RECV, DROP, HOLD.
- RECV:
  - Each accepted beat is written to buffer[wr_ptr], and wr_ptr increments.
  - The byte count accumulates: non-last beats add 8; the last beat adds popcount(tkeep).
  - If a non-last beat has tkeep != 8'hFF, the frame is malformed: go to DROP.
  - If a last beat has tkeep not of the contiguous-low form (0x01, 0x03 … 0xFF), the frame is malformed.
  - If wr_ptr would exceed buf_size_p/8 - 1 on a non-last beat, the frame is oversized: go to DROP.
  - If the last beat is good and tuser is 0: go to HOLD, latch packet_size_o, and assert packet_avail_o.
  - If the last beat is bad: drop_count increments, wr_ptr clears, and the state stays RECV.
- DROP:
  - Beats are accepted and discarded.
  - On tlast: drop_count increments, wr_ptr clears, go to RECV.
- HOLD:
  - Any frame whose first beat arrives in HOLD is discarded in full and counted once at its tlast. The drop is tracked with a flag and does not leave HOLD.
  - packet_ack_i: packet_avail_o falls, wr_ptr clears, go to RECV.
  - packet_ack_i is ignored outside HOLD.
- Host reads:
  - buffer_read_data_o <= buffer[buffer_read_addr_i] every cycle.
  - Contents are stable only while packet_avail_o is 1.
  - Bytes beyond packet_size_o in the last word are undefined.
- drop_count_o saturates at 16'hFFFF.

## Timing
- Reset values: rx_axis_tready_o 0 during reset, 1 from the first clock after release. packet_avail_o 0, packet_size_o 0, drop_count_o 0, buffer_read_data_o 0, state RECV. Buffer contents are not reset.
- packet_avail_o rises in the cycle after the good tlast beat is accepted.
- Buffer release: packet_ack_i sampled in cycle N gives packet_avail_o=0 and state RECV in cycle N+1.
  - A first beat arriving in cycle N belongs to HOLD and is dropped.
  - A first beat arriving in cycle N+1 is received.
- Read latency is 1 cycle.
- Frame boundary: back-to-back frames (tlast followed immediately by a new first beat) are legal in every state.
- Single-beat frames are legal.
- Reset asserted mid-frame aborts the frame without counting it. After reset, the first beat seen is treated as a first beat.

## Configuration
- ETHERNET_RECEIVER_DROP_ERR_EN:
  - Defined: frames with tuser=1 on tlast are dropped and counted.
  - Undefined: tuser is ignored, and such frames are delivered as good frames.

## Structure
- Package ethernet_pkg holds:
  - the rx state enum (RECV/DROP/HOLD);
  - the tkeep-valid and tkeep-to-count helper constants.
- One sub-module, ethernet_tkeep_decode: combinational; takes 8-bit tkeep and outputs byte count (0–8) plus a contiguous-valid flag. Used by the last-beat check.

## Test plan
- 60-byte frame (7 full beats + last tkeep=0x0F) -> packet_avail_o=1 one cycle after tlast; packet_size_o=60; read addr 7 returns the last word low 4 bytes.
- A second frame arrives during HOLD, then packet_ack_i is given -> drop_count_o=1; the first frame's data is unchanged; the next frame is received with correct size.
- 2056-byte frame -> no packet_avail_o; drop_count_o increments by 1; the next 64-byte frame is received correctly.
- Non-last beat with tkeep=0x7F, and a separate frame whose last beat has tkeep=0x05 -> each dropped; drop_count_o +2.
- tuser=1 on tlast of a 64-byte frame -> dropped with ETHERNET_RECEIVER_DROP_ERR_EN defined; delivered with size 64 without it.
- reset_n_i pulsed low mid-frame, then a 16-byte frame -> all outputs at reset values; the 16-byte frame yields packet_size_o=16 and drop_count_o=0.

Source files
------------

// File: rtl/ethernet_pkg.sv
// Shared types and tkeep helpers for the Ethernet AXI-Stream receive path.
package ethernet_pkg;

    typedef enum logic [1:0] {
        RECV = 2'd0,
        DROP = 2'd1,
        HOLD = 2'd2
    } rx_state_e;

    localparam int unsigned BEAT_BYTES        = 8;
    localparam int unsigned TKEEP_COUNT_WIDTH = 4;
    localparam logic [7:0]  TKEEP_FULL        = 8'hFF;

    // Contiguous-low means keep+1 is a power of two (0x01, 0x03 ... 0xFF); 0x00 is rejected.
    function automatic logic tkeep_contiguous(input logic [7:0] keep);
        return (keep != 8'h00) && ((keep & (keep + 8'h01)) == 8'h00);
    endfunction

endpackage

// File: rtl/ethernet_tkeep_decode.sv
// Combinational tkeep decode: byte count (0-8) and contiguous-low validity flag.
module ethernet_tkeep_decode
    import ethernet_pkg::*;
(
    input  logic [7:0]                   keep,
    output logic [TKEEP_COUNT_WIDTH-1:0] byte_count,
    output logic                         valid
);

    always_comb begin
        byte_count = '0;
        for (int i = 0; i < 8; i++) begin
            byte_count = byte_count + {3'b000, keep[i]};
        end
        valid = tkeep_contiguous(keep);
    end

endmodule

// File: rtl/ethernet_axis_receiver.sv
// Single-buffer AXI-Stream frame receiver with host readout and drop counting.
// Define ETHERNET_RECEIVER_DROP_ERR_EN to discard frames flagged by tuser on tlast.
module ethernet_axis_receiver
    import ethernet_pkg::*;
#(
    parameter  int buf_size_p   = 2048,
    parameter  int recv_width_p = 8,
    localparam int size_width   = $clog2(buf_size_p) + 1,
    localparam int addr_width   = $clog2(buf_size_p / recv_width_p)
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [63:0]           rx_axis_tdata_i,
    input  logic [7:0]            rx_axis_tkeep_i,
    input  logic                  rx_axis_tvalid_i,
    input  logic                  rx_axis_tlast_i,
    input  logic                  rx_axis_tuser_i,
    output logic                  rx_axis_tready_o,
    output logic                  packet_avail_o,
    output logic [size_width-1:0] packet_size_o,
    input  logic                  packet_ack_i,
    input  logic [addr_width-1:0] buffer_read_addr_i,
    output logic [63:0]           buffer_read_data_o,
    output logic [15:0]           drop_count_o
);

    localparam int                    words     = buf_size_p / recv_width_p;
    localparam logic [addr_width-1:0] last_addr = addr_width'(words - 1);

    if (recv_width_p != 8) begin : g_width_check
        $error("ethernet_axis_receiver: only recv_width_p = 8 is supported");
    end

    logic [63:0]                  buffer [words];
    rx_state_e                    state;
    logic [addr_width-1:0]        wr_ptr;
    logic [size_width-1:0]        byte_cnt;
    logic                         hold_in_frame;
    logic                         rx_ready;
    logic [TKEEP_COUNT_WIDTH-1:0] last_count;
    logic                         last_valid;
    logic                         last_good;
    logic                         beat;
    logic                         hold_mid_next;
    logic [15:0]                  drop_inc;
    logic                         unused_tuser;

    ethernet_tkeep_decode u_tkeep_decode (
        .keep       (rx_axis_tkeep_i),
        .byte_count (last_count),
        .valid      (last_valid)
    );

`ifdef ETHERNET_RECEIVER_DROP_ERR_EN
    assign last_good    = last_valid & ~rx_axis_tuser_i;
    assign unused_tuser = 1'b0;
`else
    assign last_good    = last_valid;
    assign unused_tuser = rx_axis_tuser_i;
`endif

    assign rx_axis_tready_o = rx_ready;
    assign beat             = rx_axis_tvalid_i & rx_ready;
    assign drop_inc         = (drop_count_o == 16'hFFFF) ? drop_count_o : drop_count_o + 16'd1;
    // A frame started in HOLD that is still mid-flight at release must finish in DROP.
    assign hold_mid_next    = beat ? ~rx_axis_tlast_i : hold_in_frame;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state          <= RECV;
            wr_ptr         <= '0;
            byte_cnt       <= '0;
            hold_in_frame  <= 1'b0;
            rx_ready       <= 1'b0;
            packet_avail_o <= 1'b0;
            packet_size_o  <= '0;
            drop_count_o   <= '0;
        end else begin
            rx_ready <= 1'b1;
            case (state)
                RECV: begin
                    if (beat) begin
                        if (!rx_axis_tlast_i) begin
                            if (rx_axis_tkeep_i != TKEEP_FULL || wr_ptr == last_addr) begin
                                state <= DROP;
                            end else begin
                                wr_ptr   <= wr_ptr + addr_width'(1);
                                byte_cnt <= byte_cnt + size_width'(BEAT_BYTES);
                            end
                        end else if (last_good) begin
                            state          <= HOLD;
                            packet_avail_o <= 1'b1;
                            packet_size_o  <= byte_cnt + size_width'(last_count);
                            byte_cnt       <= '0;
                        end else begin
                            drop_count_o <= drop_inc;
                            wr_ptr       <= '0;
                            byte_cnt     <= '0;
                        end
                    end
                end
                DROP: begin
                    if (beat && rx_axis_tlast_i) begin
                        drop_count_o <= drop_inc;
                        wr_ptr       <= '0;
                        byte_cnt     <= '0;
                        state        <= RECV;
                    end
                end
                HOLD: begin
                    if (beat && rx_axis_tlast_i) begin
                        drop_count_o <= drop_inc;
                    end
                    if (packet_ack_i) begin
                        packet_avail_o <= 1'b0;
                        wr_ptr         <= '0;
                        hold_in_frame  <= 1'b0;
                        state          <= hold_mid_next ? DROP : RECV;
                    end else if (beat) begin
                        hold_in_frame <= ~rx_axis_tlast_i;
                    end
                end
                default: state <= RECV;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == RECV && beat) begin
            buffer[wr_ptr] <= rx_axis_tdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            buffer_read_data_o <= '0;
        end else begin
            buffer_read_data_o <= buffer[buffer_read_addr_i];
        end
    end

endmodule
